reg_operand_fetch: RTL
======================

Name: reg_operand_fetch

Overview:
- Operand-fetch stage sitting directly upstream of the register file.
- Accepts decoded source-register indices from decode.
- Drives read ports A and B of the register file with the valid/ack handshake and captures the returned data.
- Presents both operands plus an instruction tag to execute over a valid/ready handshake.

Parameters:
- TAG_W, 32, width of the opaque instruction payload carried alongside the operands.
- ACK_TIMEOUT, 64, cycles a read request may stay unacked before the sticky error flag sets; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dec_valid  in  1  decode offers an instruction
- dec_ready  out  1  stage can accept (IDLE only)
- dec_rs1  in  5  source register 1 index
- dec_rs2  in  5  source register 2 index
- dec_rs1_used  in  1  rs1 is a real operand
- dec_rs2_used  in  1  rs2 is a real operand
- dec_tag  in  TAG_W  instruction payload
- reg_rd_addr_a  out  5  port A read address
- reg_rd_addr_a_valid  out  1  port A request
- reg_rd_data_a  in  32  port A data, valid in the ack cycle
- reg_rd_data_a_ack  in  1  port A single-cycle ack
- reg_rd_addr_b  out  5  port B read address
- reg_rd_addr_b_valid  out  1  port B request
- reg_rd_data_b  in  32  port B data, valid in the ack cycle
- reg_rd_data_b_ack  in  1  port B single-cycle ack
- opf_valid  out  1  operands ready for execute
- opf_ready  in  1  execute accepts
- opf_rs1_data  out  32  operand 1
- opf_rs2_data  out  32  operand 2
- opf_tag  out  TAG_W  payload
- opf_err  out  1  sticky ack-timeout flag

Behaviour:
- Reset (synchronous, active-high, clk):
  - State=IDLE; dec_ready=1; all other outputs 0.
  - opf_err cleared.
  - An in-flight request is abandoned; a late ack arriving after reset is ignored.
- FSM states: IDLE, FETCH, HOLD.
- IDLE:
  - dec_ready=1. Accept on dec_valid&dec_ready at cycle N; latch rs1/rs2/used/tag.
  - Port A needed iff rs1_used && rs1!=0; port B needed iff rs2_used && rs2!=0.
  - An unneeded operand is captured as 32'h0.
  - If neither port is needed: go to HOLD, opf_valid=1 at N+1.
  - Otherwise go to FETCH; needed *_valid=1 with the address from N+1 (registered).
- FETCH:
  - Each port runs independently. Address and valid are held stable until that port's ack.
  - Data is captured on the ack cycle; valid drops in the next cycle.
  - An ack while the port's valid=0 is ignored.
  - When all needed ports have acked (same or different cycles), go to HOLD. opf_valid=1 the cycle after the last ack.
  - Minimum latency: accept at N, combinational ack at N+1, opf_valid at N+2.
- HOLD:
  - opf_valid=1 with opf_rs1_data, opf_rs2_data and opf_tag stable until opf_ready.
  - On opf_valid&opf_ready: back to IDLE, opf_valid=0 next cycle.
  - No new accept in the same cycle; throughput is one instruction per ≥2 cycles.
- rs1==rs2 (both needed): both ports are still issued; each captures its own data.
- Watchdog:
  - Counter is cleared on entry to FETCH and increments each FETCH cycle with any ack outstanding.
  - At ACK_TIMEOUT, opf_err=1 (sticky until reset). The FSM keeps waiting; there is no recovery.

Optional Feature:
- Macro: REG_OPF_WB_BYPASS_EN.
- When defined:
  - Extra inputs reg_wr_addr[4:0], reg_wr_data[31:0], reg_wr_data_valid, reg_wr_ack.
  - In FETCH, if reg_wr_data_valid&reg_wr_ack targets a latched needed source register in the same cycle as that port's ack, reg_wr_data is captured instead of reg_rd_data (write-before-read).
  - A write to x0 is never bypassed.
- When undefined: the ports are absent; only read data is used.

Decomposition:
- Package reg_opf_pkg:
  - typedef reg_idx_t (logic[4:0]), xlen_data_t (logic[31:0]).
  - enum opf_state_e {IDLE, FETCH, HOLD}.
  - localparam REG_ZERO=5'd0.
- One sub-module: reg_opf_rd_port, instantiated twice (A, B).
  - Holds the per-port request/valid/ack tracking, data capture register and bypass mux.
  - Top level holds the FSM, watchdog and output registers.

Test Plan:
- rs1=5, rs2=7 both used; slave acks A at N+1 with 32'hDEAD_BEEF and B at N+3 with 32'h1234_5678 -> opf_valid at N+4 with those operands; A valid low from N+2; B valid held N+1..N+3.
- rs1=0 used, rs2_used=0 -> no port valid ever asserted; opf_valid at N+1 with both operands 0.
- opf_ready held low 10 cycles in HOLD -> outputs stable, dec_ready=0; ready pulse -> IDLE, dec_ready=1 the next cycle.
- ACK_TIMEOUT=8, no ack on port B -> opf_err=1 after 8 FETCH cycles; reset -> opf_err=0, IDLE, and a late ack is ignored.
- reset asserted mid-FETCH after A acked -> all outputs 0 next cycle; a new instruction completes normally.
- With REG_OPF_WB_BYPASS_EN: rs1=3; write x3=32'hCAFE_0001 acked in the same cycle as A ack returning 32'h0 -> opf_rs1_data=32'hCAFE_0001; the same scenario to x0 -> 0.

Source files
------------

// File: rtl/reg_opf_pkg.sv
// reg_opf_pkg: shared types and constants for the operand-fetch stage.
package reg_opf_pkg;
  typedef logic [4:0] reg_idx_t;
  typedef logic [31:0] xlen_data_t;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} opf_state_e;
  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_opf_rd_port.sv
// reg_opf_rd_port: one register-file read port; request tracking, data capture and
// optional write-before-read bypass (REG_OPF_WB_BYPASS_EN).
module reg_opf_rd_port
  import reg_opf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        need_i,
  input  logic [4:0]  idx_i,
  input  logic [31:0] rd_data_i,
  input  logic        ack_i,
`ifdef REG_OPF_WB_BYPASS_EN
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_fire_i,
`endif
  output logic [4:0]  addr_o,
  output logic        valid_o,
  output logic [31:0] data_o
);
  reg_idx_t addr_q, addr_d;
  xlen_data_t data_q, data_d, cap;
  logic valid_q, valid_d;
  always_comb begin
`ifdef REG_OPF_WB_BYPASS_EN
    cap = (wr_fire_i && wr_addr_i == addr_q && addr_q != REG_ZERO) ? wr_data_i : rd_data_i;
`else
    cap = rd_data_i;
`endif
    valid_d = start_i ? need_i : valid_q & ~ack_i;
    addr_d = start_i ? (need_i ? idx_i : REG_ZERO) : addr_q;
    data_d = start_i ? '0 : (valid_q & ack_i) ? cap : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q <= REG_ZERO;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign addr_o = addr_q;
  assign valid_o = valid_q;
  assign data_o = data_q;
endmodule

// File: rtl/reg_operand_fetch.sv
// reg_operand_fetch: fetches two source operands from the register file and hands them to execute.
// Optional write-back bypass enabled by REG_OPF_WB_BYPASS_EN.
module reg_operand_fetch
  import reg_opf_pkg::*;
#(
  parameter int TAG_W = 32,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic [TAG_W-1:0] dec_tag,
  output logic [4:0]       reg_rd_addr_a,
  output logic             reg_rd_addr_a_valid,
  input  logic [31:0]      reg_rd_data_a,
  input  logic             reg_rd_data_a_ack,
  output logic [4:0]       reg_rd_addr_b,
  output logic             reg_rd_addr_b_valid,
  input  logic [31:0]      reg_rd_data_b,
  input  logic             reg_rd_data_b_ack,
`ifdef REG_OPF_WB_BYPASS_EN
  input  logic [4:0]       reg_wr_addr,
  input  logic [31:0]      reg_wr_data,
  input  logic             reg_wr_data_valid,
  input  logic             reg_wr_ack,
`endif
  output logic             opf_valid,
  input  logic             opf_ready,
  output logic [31:0]      opf_rs1_data,
  output logic [31:0]      opf_rs2_data,
  output logic [TAG_W-1:0] opf_tag,
  output logic             opf_err
);
  localparam int CW = ACK_TIMEOUT > 0 ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(ACK_TIMEOUT);
  opf_state_e state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, accept, need_a, need_b, last, stall;
  reg_opf_rd_port u_port_a (
    .clk(clk), .reset(reset), .start_i(accept), .need_i(need_a), .idx_i(dec_rs1),
    .rd_data_i(reg_rd_data_a), .ack_i(reg_rd_data_a_ack),
`ifdef REG_OPF_WB_BYPASS_EN
    .wr_addr_i(reg_wr_addr), .wr_data_i(reg_wr_data), .wr_fire_i(reg_wr_data_valid & reg_wr_ack),
`endif
    .addr_o(reg_rd_addr_a), .valid_o(reg_rd_addr_a_valid), .data_o(opf_rs1_data)
  );
  reg_opf_rd_port u_port_b (
    .clk(clk), .reset(reset), .start_i(accept), .need_i(need_b), .idx_i(dec_rs2),
    .rd_data_i(reg_rd_data_b), .ack_i(reg_rd_data_b_ack),
`ifdef REG_OPF_WB_BYPASS_EN
    .wr_addr_i(reg_wr_addr), .wr_data_i(reg_wr_data), .wr_fire_i(reg_wr_data_valid & reg_wr_ack),
`endif
    .addr_o(reg_rd_addr_b), .valid_o(reg_rd_addr_b_valid), .data_o(opf_rs2_data)
  );
  always_comb begin
    accept = dec_valid && state_q == IDLE;
    need_a = dec_rs1_used && dec_rs1 != REG_ZERO;
    need_b = dec_rs2_used && dec_rs2 != REG_ZERO;
    last = (!reg_rd_addr_a_valid || reg_rd_data_a_ack) && (!reg_rd_addr_b_valid || reg_rd_data_b_ack);
    state_d = state_q == IDLE ? (accept ? ((need_a || need_b) ? FETCH : HOLD) : IDLE)
            : state_q == FETCH ? (last ? HOLD : FETCH)
            : (opf_ready ? IDLE : HOLD);
    tag_d = accept ? dec_tag : tag_q;
    // a cycle counts toward the timeout only if some request is still unacked after it
    stall = state_q == FETCH && ((reg_rd_addr_a_valid && !reg_rd_data_a_ack) ||
                                 (reg_rd_addr_b_valid && !reg_rd_data_b_ack));
    cnt_d = accept ? '0 : (stall && cnt_q != LIM) ? cnt_q + CW'(1) : cnt_q;
    err_d = err_q || (ACK_TIMEOUT != 0 && stall && cnt_d == LIM);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tag_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign dec_ready = state_q == IDLE;
  assign opf_valid = state_q == HOLD;
  assign opf_tag = tag_q;
  assign opf_err = err_q;
endmodule
